tennis_rally_ctrl: RTL and testbench
====================================

Name: tennis_rally_ctrl

Overview:
- Sequences one tennis rally game on the 16-LED court: serve, ball travel, hit detection, point award, scoring and end of game.
- Sits between the debounced player buttons (but_1, but_2) and the board LEDs inside top.
- Owns the ball position, direction, step timing and both scores.
- Player 1 owns the led[15] end of the court. Player 2 owns the led[0] end.

Parameters:
- STEP_DIV, 4, clk cycles per ball step. Synthesis overrides this to a human-visible rate. Must be ≥2.
- POINT_HOLD, 2, number of step periods the point-flash is shown.
- WIN_SCORE, 5, points needed to win. Range 1..15.

Ports:
- clk  in  1  system clock, rising edge
- reset_clk  in  1  synchronous, active-high reset
- but_1  in  1  player 1 button, debounced level, synchronous to clk
- but_2  in  1  player 2 button, debounced level, synchronous to clk
- leds  out  16  court display
- score_1  out  4  player 1 points
- score_2  out  4  player 2 points
- game_over  out  1  high once a player reaches WIN_SCORE
- winner  out  1  0 = player 1, 1 = player 2; valid only while game_over=1

Behaviour:
- Reset (reset_clk sampled high on a clk edge):
  - state=SERVE, server=P1, pos=15, dir=toward 0, step counter=0.
  - score_1=score_2=0, game_over=0, winner=0, leds=0x8000 on the next cycle.
  - Button history registers load the current button levels, so a button held through reset does not generate an edge.
- Edge detect: press_x = but_x & ~but_x_q. Only rising edges act; held levels are ignored.
- Step tick: counter runs 0..STEP_DIV-1 and tick=1 when it equals STEP_DIV-1. The counter clears on launch, hit and state entry.
- leds decode is combinational from registered state/pos, with no added latency:
  - SERVE/MOVE: one-hot 1<<pos.
  - POINT: 0xFFFF.
  - OVER: 0xFF00 if winner=0, 0x00FF if winner=1.
- State SERVE:
  - Ball held at pos 15 for P1, pos 0 for P2.
  - Only the server's press is accepted → MOVE. dir points away from the server; the first step occurs STEP_DIV cycles later.
  - Receiver presses are ignored.
- State MOVE:
  - On tick, if pos is not the receiving endpoint, pos steps one toward it.
  - Receiving endpoint: pos 0 when travelling toward P2, pos 15 when travelling toward P1.
  - Hit: the receiver presses while pos == receiving endpoint → dir reverses, counter clears, pos moves off the endpoint STEP_DIV cycles later.
  - Presses at any other pos, and presses by the player who last hit, are ignored. There is no fault.
  - Miss: tick while pos == receiving endpoint with no hit → POINT. The opponent of the receiver wins the point.
  - Hit press and tick in the same cycle: the hit wins.
- State POINT:
  - The winner's score increments on entry.
  - leds=0xFFFF for POINT_HOLD*STEP_DIV cycles.
  - If the new score == WIN_SCORE → OVER. Otherwise → SERVE with server = point winner.
- State OVER:
  - game_over=1 and winner is set.
  - All buttons are ignored and scores are frozen until reset.
- Scores never exceed WIN_SCORE; no wrap-around is possible.
- Reset in any state, including mid-step, mid-flash or OVER, wins over every other event in that cycle.

Test Plan:
1. Serve and miss: reset, then but_1 rises at cycle k.
   - leds=0x8000 through k+3, 0x4000 at k+4, then shifts right every 4 cycles, reaching 0x0001 at k+60.
   - No press → leds=0xFFFF from k+64 for 8 cycles, score_1=1.
   - Then leds=0x8000 with P1 serving.
2. Return hit: as in 1, but but_2 rises while leds=0x0001.
   - 4 cycles later leds=0x0002, then travels back to 0x8000.
   - but_1 press at 0x8000 reverses again. Scores stay 0.
3. Early/illegal presses:
   - but_2 rises at pos 5 while the ball travels to P2; but_1 rises at the same time.
   - Both ignored; the ball continues; a miss at pos 0 still awards P1.
   - A held but_1 generates no extra launches.
4. Hit/tick coincidence: but_2 edge lands exactly on the cycle tick fires at pos 0 → hit accepted, no point.
5. Game over: P2 wins 5 points, serving after each.
   - After the 5th flash: leds=0x00FF, game_over=1, winner=1, score_2=5.
   - Subsequent presses change nothing.
6. Reset mid-rally: assert reset_clk for 1 cycle with the ball at 0x0100 and score_1=2.
   - Next cycle: leds=0x8000, score_1=score_2=0, game_over=0.
   - A held but_1 does not launch until released and re-pressed.

Source files
------------

// File: rtl/tennis_rally_ctrl.sv
// tennis_rally_ctrl: serve, ball travel, hit/miss detection and scoring for a 16-LED tennis rally game
module tennis_rally_ctrl #(
  parameter int STEP_DIV   = 4,
  parameter int POINT_HOLD = 2,
  parameter int WIN_SCORE  = 5
) (
  input  logic        clk,
  input  logic        reset_clk,
  input  logic        but_1,
  input  logic        but_2,
  output logic [15:0] leds,
  output logic [3:0]  score_1,
  output logic [3:0]  score_2,
  output logic        game_over,
  output logic        winner
);
  localparam logic [1:0] S_SERVE = 2'd0;
  localparam logic [1:0] S_MOVE  = 2'd1;
  localparam logic [1:0] S_POINT = 2'd2;
  localparam logic [1:0] S_OVER  = 2'd3;
  localparam int CW = $clog2(STEP_DIV);
  localparam int HW = $clog2(POINT_HOLD) + 1;
  logic [1:0]    r_state;
  logic [3:0]    r_pos;
  logic          r_dir;
  logic [CW-1:0] r_cnt;
  logic [HW-1:0] r_hold;
  logic          r_win;
  logic [3:0]    r_s1, r_s2;
  logic          r_b1q, r_b2q;
  logic          w_press_1, w_press_2, w_tick, w_rx_press, w_srv_press, w_at_end, w_won;
  // r_dir=1 means the ball travels toward pos 15 (player 1 receives); r_win doubles as the server
  assign w_press_1   = but_1 & ~r_b1q;
  assign w_press_2   = but_2 & ~r_b2q;
  assign w_tick      = r_cnt == CW'(STEP_DIV - 1);
  assign w_at_end    = r_pos == (r_dir ? 4'd15 : 4'd0);
  assign w_rx_press  = r_dir ? w_press_1 : w_press_2;
  assign w_srv_press = r_win ? w_press_2 : w_press_1;
  assign w_won       = (r_win ? r_s2 : r_s1) == 4'(WIN_SCORE);
  // Button history always tracks the levels, so a press held through reset makes no edge
  always_ff @(posedge clk) begin
    r_b1q <= but_1;
    r_b2q <= but_2;
  end
  // Game sequencer: step timing, ball motion, hit/miss resolution and scoring
  always_ff @(posedge clk) begin
    if (reset_clk) begin
      r_state <= S_SERVE;
      r_pos   <= 4'd15;
      r_dir   <= 1'b0;
      r_cnt   <= '0;
      r_hold  <= '0;
      r_win   <= 1'b0;
      r_s1    <= 4'd0;
      r_s2    <= 4'd0;
    end else begin
      r_cnt <= w_tick ? '0 : r_cnt + 1'b1;
      case (r_state)
        S_SERVE: if (w_srv_press) begin
          r_state <= S_MOVE;
          r_dir   <= r_win;
          r_cnt   <= '0;
        end
        S_MOVE: if (w_rx_press && w_at_end) begin
          r_dir <= ~r_dir;
          r_cnt <= '0;
        end else if (w_tick && w_at_end) begin
          r_state <= S_POINT;
          r_win   <= r_dir;
          r_hold  <= '0;
          if (r_dir) r_s2 <= r_s2 + 4'd1;
          else r_s1 <= r_s1 + 4'd1;
        end else if (w_tick) begin
          r_pos <= r_dir ? r_pos + 4'd1 : r_pos - 4'd1;
        end
        S_POINT: if (w_tick) begin
          if (r_hold == HW'(POINT_HOLD - 1)) begin
            r_state <= w_won ? S_OVER : S_SERVE;
            r_pos   <= r_win ? 4'd0 : 4'd15;
          end else begin
            r_hold <= r_hold + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end
  // Court display decoded straight from registered state
  always_comb begin
    leds = r_state == S_POINT ? 16'hFFFF :
           r_state == S_OVER  ? (r_win ? 16'h00FF : 16'hFF00) :
           16'h0001 << r_pos;
  end
  assign score_1   = r_s1;
  assign score_2   = r_s2;
  assign game_over = r_state == S_OVER;
  assign winner    = r_win;
endmodule

// File: tb/tb_tennis_rally_ctrl.sv
// tb_tennis_rally_ctrl: randomized rally stimulus scored against a timestamp-based game model
module tb_tennis_rally_ctrl;
  localparam int SD = 4;
  localparam int PH = 2;
  localparam int WS = 5;
  logic        clk = 1'b0;
  logic        reset_clk = 1'b1;
  logic        but_1 = 1'b0;
  logic        but_2 = 1'b0;
  logic [15:0] leds;
  logic [3:0]  score_1, score_2;
  logic        game_over, winner;
  tennis_rally_ctrl #(.STEP_DIV(SD), .POINT_HOLD(PH), .WIN_SCORE(WS)) dut (
    .clk(clk), .reset_clk(reset_clk), .but_1(but_1), .but_2(but_2),
    .leds(leds), .score_1(score_1), .score_2(score_2),
    .game_over(game_over), .winner(winner)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic [15:0] leds;
    logic [3:0]  s1, s2;
    logic        go, win, cw;
  } exp_t;
  typedef enum int {G_SERVE, G_MOVE, G_POINT, G_OVER} ph_t;
  exp_t q[$];
  int compared = 0;
  int mismatched = 0;
  int overs = 0;
  ph_t  ph = G_SERVE;
  int   srv = 0, t0 = 0, to = 2, tp = 0, pw = 1, n = 0;
  int   sc[2] = '{0, 0};
  logic h1 = 1'b0, h2 = 1'b0;
  // Model of one clock edge in absolute time: ball position is (edge - launch)/SD from its origin
  task automatic model_step(input logic r, input logic c1, input logic c2);
    logic p1, p2, rxp;
    int el, st;
    exp_t e;
    p1 = c1 & ~h1;
    p2 = c2 & ~h2;
    h1 = c1;
    h2 = c2;
    n++;
    if (r) begin
      ph = G_SERVE; srv = 0; sc[0] = 0; sc[1] = 0;
    end else begin
      case (ph)
        G_SERVE: if ((srv == 0 && p1) || (srv == 1 && p2)) begin
          ph = G_MOVE; t0 = n; to = srv == 0 ? 2 : 1;
        end
        G_MOVE: begin
          el = n - t0;
          rxp = to == 2 ? p2 : p1;
          if (rxp && el > 15 * SD) begin
            t0 = n; to = 3 - to;
          end else if (el == 16 * SD) begin
            ph = G_POINT; tp = n; pw = 3 - to; sc[pw-1]++;
          end
        end
        G_POINT: if (n - tp == PH * SD) begin
          if (sc[pw-1] == WS) begin
            ph = G_OVER; overs++;
          end else begin
            ph = G_SERVE; srv = pw - 1;
          end
        end
        default: ;
      endcase
    end
    e.s1 = 4'(sc[0]);
    e.s2 = 4'(sc[1]);
    e.go = ph == G_OVER;
    e.cw = r || ph == G_OVER;
    e.win = r ? 1'b0 : 1'(pw - 1);
    case (ph)
      G_SERVE: e.leds = srv == 0 ? 16'h8000 : 16'h0001;
      G_MOVE: begin
        st = (n - t0) / SD;
        if (st > 15) st = 15;
        e.leds = 16'h0001 << (to == 2 ? 15 - st : st);
      end
      G_POINT: e.leds = 16'hFFFF;
      default: e.leds = pw == 1 ? 16'hFF00 : 16'h00FF;
    endcase
    q.push_back(e);
  endtask
  // Player i presses eagerly in the hit window, occasionally when serving, rarely otherwise
  function automatic logic drv(logic cur, int i);
    int el;
    bit want;
    el = n + 1 - t0;
    if (cur) return $urandom_range(0, 1) == 0;
    if (ph == G_MOVE && to == i && el > 15 * SD && el <= 16 * SD) want = $urandom_range(0, 1) == 0;
    else if (ph == G_SERVE && srv == i - 1) want = $urandom_range(0, 5) == 0;
    else want = $urandom_range(0, 19) == 0;
    return want;
  endfunction
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        exp_t e;
        e = q.pop_front();
        compared++;
        if (leds !== e.leds || score_1 !== e.s1 || score_2 !== e.s2 || game_over !== e.go ||
            (e.cw && winner !== e.win)) begin
          mismatched++;
          $display("FAIL outputs t=%0t: got leds=%h s1=%0d s2=%0d go=%b win=%b, want leds=%h s1=%0d s2=%0d go=%b win=%b(chk %b)",
                   $time, leds, score_1, score_2, game_over, winner, e.leds, e.s1, e.s2, e.go, e.win, e.cw);
        end
      end
    end
  end
  initial begin
    int over_cnt;
    over_cnt = 0;
    for (int c = 0; c < 30000; c++) begin
      @(negedge clk);
      over_cnt = ph == G_OVER ? over_cnt + 1 : 0;
      reset_clk = c < 3 || over_cnt > 30 || $urandom_range(0, 2499) == 0;
      but_1 = drv(but_1, 1);
      but_2 = drv(but_2, 2);
      model_step(reset_clk, but_1, but_2);
    end
    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
    #2;
    if (q.size() != 0) begin
      compared++;
      mismatched++;
      $display("FAIL drain: %0d expectations left, want 0", q.size());
    end
    $display("games finished: %0d", overs);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
